// File: rtl/icache_fill_ctrl.sv
// Miss/refill sequencer for a 4-slot instruction cache line: requests missing slots from L2,
// writes the returned beat through the fill port and follows each demand fill with a next-line prefetch.
module icache_fill_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter bit          PF_ENABLE   = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fetch_valid,
  input  logic [63:0]  fetch_addr,
  input  logic [3:0]   fetch_hit,
  output logic         fetch_stall,
  output logic         l2_req,
  output logic [63:0]  l2_addr,
  output logic [3:0]   l2_mask,
  input  logic         l2_ack,
  input  logic         l2_rvalid,
  input  logic [255:0] l2_rdata,
  input  logic         l2_rerr,
  input  logic         snoop_valid,
  input  logic [63:0]  snoop_addr,
  output logic [255:0] fill_addr,
  output logic [255:0] fill_data,
  output logic [3:0]   fill_start,
  output logic         busy,
  output logic [7:0]   stat_drop
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WRITE} state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [63:0] base_q, base_d;
  logic [63:0] pf_addr_q, pf_addr_d;
  logic [3:0]  mask_q, mask_d;
  logic        kind_pf_q, kind_pf_d;
  logic        pf_pending_q, pf_pending_d;
  logic        poison_q, poison_d;
  logic [7:0]  timer_q, timer_d;
  logic [63:0] slot_addr [4];
  logic [3:0]  snoop_match;
  logic        demand, drop, capture;

  assign demand      = fetch_valid && (fetch_hit != 4'b1111);
  assign fetch_stall = demand;
  assign l2_req      = (state_q == S_REQ);
  assign l2_addr     = base_q;
  assign l2_mask     = mask_q;

  // A store only poisons slots this fill actually requested.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      slot_addr[k]   = base_q + (64'(k) << 3);
      snoop_match[k] = snoop_valid && mask_q[k] && (snoop_addr == slot_addr[k]);
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    mask_d       = mask_q;
    kind_pf_d    = kind_pf_q;
    pf_pending_d = pf_pending_q;
    pf_addr_d    = pf_addr_q;
    poison_d     = poison_q;
    timer_d      = timer_q;
    drop         = 1'b0;
    capture      = 1'b0;
    fill_start   = 4'b0000;
    unique case (state_q)
      S_IDLE: begin
        if (demand) begin
          base_d       = fetch_addr;
          mask_d       = ~fetch_hit;
          kind_pf_d    = 1'b0;
          pf_pending_d = 1'b0;
          poison_d     = 1'b0;
          state_d      = S_REQ;
        end else if (pf_pending_q) begin
          base_d       = pf_addr_q;
          mask_d       = 4'b1111;
          kind_pf_d    = 1'b1;
          pf_pending_d = 1'b0;
          poison_d     = 1'b0;
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        if (|snoop_match) poison_d = 1'b1;
        if (l2_ack) begin
          timer_d = 8'd0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (|snoop_match) poison_d = 1'b1;
        if (l2_rvalid) begin
          // A store racing the response beat also poisons it.
          if (l2_rerr || poison_q || (|snoop_match)) begin
            drop    = 1'b1;
            state_d = S_IDLE;
          end else begin
            capture = 1'b1;
            state_d = S_WRITE;
          end
        end else if (timer_q == TIMER_LAST) begin
          drop    = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_WRITE: begin
        fill_start = mask_q & ~snoop_match;
        state_d    = S_IDLE;
        if (!kind_pf_q && PF_ENABLE) begin
          pf_pending_d = 1'b1;
          pf_addr_d    = base_q + 64'd32;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      mask_q       <= '0;
      kind_pf_q    <= 1'b0;
      pf_pending_q <= 1'b0;
      pf_addr_q    <= '0;
      poison_q     <= 1'b0;
      timer_q      <= '0;
      busy         <= 1'b0;
      stat_drop    <= '0;
      fill_data    <= '0;
      fill_addr    <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      mask_q       <= mask_d;
      kind_pf_q    <= kind_pf_d;
      pf_pending_q <= pf_pending_d;
      pf_addr_q    <= pf_addr_d;
      poison_q     <= poison_d;
      timer_q      <= timer_d;
      busy         <= (state_d != S_IDLE);
      if (drop && (stat_drop != 8'hFF)) stat_drop <= stat_drop + 8'd1;
      if (capture) begin
        fill_data <= l2_rdata;
        fill_addr <= {slot_addr[3], slot_addr[2], slot_addr[1], slot_addr[0]};
      end
    end
  end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Randomized transaction-level bench for icache_fill_ctrl; expectations come from a
// per-fill outcome model (drop count, pending prefetch address, expected write mask).
module tb_icache_fill_ctrl;

  localparam int TMO = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         fetch_valid;
  logic [63:0]  fetch_addr;
  logic [3:0]   fetch_hit;
  logic         fetch_stall;
  logic         l2_req;
  logic [63:0]  l2_addr;
  logic [3:0]   l2_mask;
  logic         l2_ack;
  logic         l2_rvalid;
  logic [255:0] l2_rdata;
  logic         l2_rerr;
  logic         snoop_valid;
  logic [63:0]  snoop_addr;
  logic [255:0] fill_addr;
  logic [255:0] fill_data;
  logic [3:0]   fill_start;
  logic         busy;
  logic [7:0]   stat_drop;

  icache_fill_ctrl #(.TIMEOUT_CYC(TMO), .PF_ENABLE(1'b1)) dut (
    .clk(clk), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_hit(fetch_hit),
    .fetch_stall(fetch_stall),
    .l2_req(l2_req), .l2_addr(l2_addr), .l2_mask(l2_mask), .l2_ack(l2_ack),
    .l2_rvalid(l2_rvalid), .l2_rdata(l2_rdata), .l2_rerr(l2_rerr),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
    .fill_addr(fill_addr), .fill_data(fill_data), .fill_start(fill_start),
    .busy(busy), .stat_drop(stat_drop)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state: outcome-level, not cycle-level.
  int          exp_drops  = 0;
  bit          pf_pend_m  = 1'b0;
  logic [63:0] pf_addr_m  = '0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic note_drop();
    if (exp_drops < 255) exp_drops++;
  endtask

  // Random fetch traffic while busy: must stall on a miss but never be captured.
  task automatic random_fetch();
    fetch_valid = 1'($urandom_range(0, 1));
    fetch_addr  = {$urandom, $urandom};
    fetch_hit   = 4'($urandom);
    #1;
    check("stall_busy", fetch_stall, fetch_valid && (fetch_hit != 4'hF));
  endtask

  // snp: 0 none, 1 matching store before the response, 2 matching store during the write,
  //      3 non-matching store, 4 matching store in the same cycle as the response.
  task automatic run_txn(input bit use_demand, input logic [63:0] addr, input logic [3:0] hit,
                         input int ack_dly, input int rsp_dly, input bit err, input int snp,
                         input int k_sel);
    logic [63:0]  base;
    logic [3:0]   mask;
    logic [255:0] data;
    logic [255:0] exp_fa;
    logic [3:0]   exp_fs;
    logic [63:0]  other;
    bit           demand_kind, timeout, poisoned, dropped;
    int           k, nwait;

    check("idle_busy", busy, 1'b0);
    if (use_demand) begin
      base = addr; mask = ~hit; demand_kind = 1'b1;
      fetch_valid = 1'b1; fetch_addr = addr; fetch_hit = hit;
    end else begin
      base = pf_addr_m; mask = 4'hF; demand_kind = 1'b0;
      fetch_valid = 1'($urandom_range(0, 1)); fetch_addr = {$urandom, $urandom}; fetch_hit = 4'hF;
    end
    #1;
    check("stall_idle", fetch_stall, use_demand);
    pf_pend_m = 1'b0;
    step();
    fetch_valid = 1'b0;
    #1;
    check("req", l2_req, 1'b1);
    check("req_addr", l2_addr, base);
    check("req_mask", l2_mask, mask);
    check("busy_req", busy, 1'b1);

    if (k_sel >= 0) k = k_sel;
    else begin
      k = $urandom_range(0, 3);
      while (!mask[k]) k = $urandom_range(0, 3);
    end
    other    = base + 64'd32 + (64'($urandom_range(0, 3)) << 3);
    timeout  = (rsp_dly >= TMO);
    poisoned = (snp == 1) && !timeout;

    for (int i = 0; i < ack_dly; i++) begin
      random_fetch();
      l2_rvalid = 1'($urandom_range(0, 1));
      l2_rdata  = {8{$urandom}};
      step();
      l2_rvalid = 1'b0;
      check("req_hold", l2_req, 1'b1);
    end
    fetch_valid = 1'b0;
    l2_ack = 1'b1;
    if (snp == 1 && rsp_dly == 0) begin snoop_valid = 1'b1; snoop_addr = base + (64'(k) << 3); end
    if (snp == 3) begin snoop_valid = 1'b1; snoop_addr = other; end
    step();
    l2_ack = 1'b0; snoop_valid = 1'b0;
    #1;
    check("req_done", l2_req, 1'b0);

    nwait = timeout ? TMO : rsp_dly;
    for (int i = 0; i < nwait; i++) begin
      random_fetch();
      if (snp == 1 && !timeout && i == nwait - 1) begin
        snoop_valid = 1'b1; snoop_addr = base + (64'(k) << 3);
      end
      step();
      snoop_valid = 1'b0;
    end
    fetch_valid = 1'b0;

    if (timeout) begin
      note_drop();
      #1;
      check("tmo_idle", busy, 1'b0);
      check("tmo_drops", stat_drop, 8'(exp_drops));
      l2_rvalid = 1'b1; l2_rdata = {8{$urandom}};
      step();
      l2_rvalid = 1'b0;
      #1;
      check("late_rvalid", fill_start, 4'b0000);
      check("late_busy", busy, 1'b0);
      return;
    end

    data = {8{$urandom}};
    l2_rvalid = 1'b1; l2_rdata = data; l2_rerr = err;
    if (snp == 4) begin snoop_valid = 1'b1; snoop_addr = base + (64'(k) << 3); end
    step();
    l2_rvalid = 1'b0; l2_rerr = 1'b0; snoop_valid = 1'b0;
    dropped = err || poisoned || (snp == 4);

    if (dropped) begin
      note_drop();
      #1;
      check("drop_idle", busy, 1'b0);
      check("drop_fill", fill_start, 4'b0000);
      check("drop_count", stat_drop, 8'(exp_drops));
      return;
    end

    exp_fs = mask;
    if (snp == 2) begin
      snoop_valid = 1'b1; snoop_addr = base + (64'(k) << 3);
      exp_fs[k] = 1'b0;
    end
    if (snp == 3) begin snoop_valid = 1'b1; snoop_addr = other; end
    for (int s = 0; s < 4; s++) exp_fa[64*s +: 64] = base + 64'(8 * s);
    #1;
    check("fill_start", fill_start, exp_fs);
    check("fill_addr", fill_addr, exp_fa);
    check("fill_data", fill_data, data);
    check("write_busy", busy, 1'b1);
    step();
    snoop_valid = 1'b0;
    #1;
    check("fill_pulse", fill_start, 4'b0000);
    check("post_idle", busy, 1'b0);
    check("post_drops", stat_drop, 8'(exp_drops));
    if (demand_kind) begin
      pf_pend_m = 1'b1;
      pf_addr_m = base + 64'd32;
    end
  endtask

  initial begin
    int      ack_dly, rsp_dly, snp;
    bit      err, use_demand;
    logic [63:0] addr;
    logic [3:0]  hit;

    reset = 1'b0;
    fetch_valid = 1'b0; fetch_addr = '0; fetch_hit = 4'hF;
    l2_ack = 1'b0; l2_rvalid = 1'b0; l2_rdata = '0; l2_rerr = 1'b0;
    snoop_valid = 1'b0; snoop_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_req", l2_req, 1'b0);
    check("rst_fill", fill_start, 4'b0000);
    check("rst_drop", stat_drop, 8'd0);
    check("rst_fdata", fill_data, 256'd0);
    check("rst_faddr", fill_addr, 256'd0);
    reset = 1'b1;
    step();

    // Demand miss, then next-line prefetch of 0x1020.
    run_txn(1'b1, 64'h1000, 4'b0011, 0, 2, 1'b0, 0, -1);
    run_txn(1'b0, 64'h0, 4'hF, 0, 1, 1'b0, 0, -1);
    // Store to 0x1008 while waiting poisons the fill.
    run_txn(1'b1, 64'h1000, 4'b0000, 0, 1, 1'b0, 1, 1);
    // No response: abandoned after TMO cycles in WAIT.
    run_txn(1'b1, 64'h2000, 4'b1010, 1, TMO, 1'b0, 0, -1);
    // Wrap of the next-line address, and a demand winning over the pending prefetch.
    run_txn(1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 4'b0000, 0, 0, 1'b0, 0, -1);
    run_txn(1'b0, 64'h0, 4'hF, 1, 0, 1'b0, 0, -1);
    run_txn(1'b1, 64'h4000, 4'b0110, 0, 0, 1'b0, 2, 0);
    run_txn(1'b1, 64'h5000, 4'b1000, 0, 0, 1'b0, 0, -1);

    // Asynchronous reset in WAIT aborts the fill; the later beat writes nothing.
    fetch_valid = 1'b1; fetch_addr = 64'h3000; fetch_hit = 4'b0000;
    step();
    fetch_valid = 1'b0; l2_ack = 1'b1;
    step();
    l2_ack = 1'b0;
    step();
    reset = 1'b0;
    #1;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_drop", stat_drop, 8'd0);
    exp_drops = 0; pf_pend_m = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    l2_rvalid = 1'b1; l2_rdata = {8{$urandom}};
    step();
    l2_rvalid = 1'b0;
    #1;
    check("rst_mid_fill", fill_start, 4'b0000);
    check("rst_mid_idle", busy, 1'b0);

    for (int t = 0; t < 200; t++) begin
      use_demand = pf_pend_m ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!pf_pend_m && $urandom_range(0, 5) == 0) begin
        fetch_valid = 1'b1; fetch_addr = {$urandom, $urandom}; fetch_hit = 4'hF;
        #1;
        check("hit_nostall", fetch_stall, 1'b0);
        step();
        fetch_valid = 1'b0;
        #1;
        check("hit_idle", busy, 1'b0);
      end
      addr = ($urandom_range(0, 7) == 0) ? (64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(0, 31)))
                                         : {$urandom, $urandom};
      hit = 4'($urandom_range(0, 14));
      ack_dly = $urandom_range(0, 3);
      rsp_dly = ($urandom_range(0, 9) < 8) ? $urandom_range(0, TMO - 1) : TMO + $urandom_range(0, 1);
      err = ($urandom_range(0, 7) == 0);
      snp = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4);
      run_txn(use_demand, addr, hit, ack_dly, rsp_dly, err, snp, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
